// File: rtl/wam_pkg.sv
// rtl/wam_pkg.sv - shared game-state encoding and constants for the game timer logic
// Contents:
//   STATE_W        width of the game state code
//   state_e        ST_IDLE=0 ST_RUN=1 ST_PAUSE=2 ST_OVER=3
//   START_SECONDS  value the countdown counter reloads to on timer_reload
//   sat_max()      all-ones value of a w-bit saturating counter
package wam_pkg;

    localparam int STATE_W       = 2;
    localparam int START_SECONDS = 20;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    function automatic int sat_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/timer_event_gen_hit_edge_filter.sv
// rtl/timer_event_gen_hit_edge_filter.sv - hit input conditioning and rising-edge pulse generation
// Build option: HIT_DEBOUNCE_EN adds a 2-flop synchronizer and a DEBOUNCE_CYC stability filter.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   hit       in   raw hit level from the hit detector
//   hit_rise  out  one-cycle pulse per accepted rising edge of hit
module hit_edge_filter #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic hit,
    output logic hit_rise
);

    if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
        $error("hit_edge_filter: DEBOUNCE_CYC must be at least 1");
    end

`ifdef HIT_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic          deb;
    logic          deb_d;
    logic [CW-1:0] stable_cnt;

    // The debounced level only follows the synchronized input after it has
    // disagreed with it for DEBOUNCE_CYC consecutive cycles; any return to
    // agreement restarts the count, so short glitches never reach deb.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            deb        <= 1'b0;
            deb_d      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1 <= hit;
            sync2 <= sync1;
            deb_d <= deb;
            if (sync2 == deb) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                deb        <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign hit_rise = deb & ~deb_d;
`else
    logic hit_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_hist <= 1'b0;
        end else begin
            hit_hist <= hit;
        end
    end

    assign hit_rise = hit & ~hit_hist;
`endif

endmodule

// File: rtl/timer_event_gen.sv
// rtl/timer_event_gen.sv - game run-state FSM and increment/decrement/reload strobe generator
// Build option: HIT_DEBOUNCE_EN (passed to hit_edge_filter) debounces the hit input.
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   start         in   level; starts a game from IDLE or OVER
//   pause         in   level; freezes the game while high in RUN/PAUSE
//   hit           in   level; each rising edge is one bonus second
//   count_zero    in   countdown counter reads 0
//   timer_reload  out  one-cycle strobe, same cycle as the accepted start
//   increment     out  one-cycle strobe, registered
//   decrement     out  one-cycle strobe, registered, priority over increment
//   state         out  IDLE=0 RUN=1 PAUSE=2 OVER=3
module timer_event_gen
    import wam_pkg::*;
#(
    parameter int TICK_DIV     = 100_000_000,
    parameter int PEND_W       = 4,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               hit,
    input  logic               count_zero,
    output logic               timer_reload,
    output logic               increment,
    output logic               decrement,
    output logic [STATE_W-1:0] state
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(sat_max(PEND_W));

    // A tick and a still-pending decrement may never coincide.
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("timer_event_gen: TICK_DIV must be at least 2");
    end
    if (PEND_W < 1) begin : g_bad_pend_w
        $error("timer_event_gen: PEND_W must be at least 1");
    end

    state_e            state_q;
    state_e            state_n;
    logic [PRE_W-1:0]  presc_q;
    logic [PRE_W-1:0]  presc_n;
    logic [PEND_W-1:0] pend_inc_q;
    logic [PEND_W-1:0] pend_inc_n;
    logic              pend_dec_q;
    logic              pend_dec_n;
    logic              reload;
    logic              reload_d;
    logic              run_active;
    logic              tick;
    logic              issue_dec;
    logic              issue_inc;
    logic              hit_rise;
    logic              hit_count;
    logic              clear_all;
    logic              inc_q;
    logic              dec_q;

    hit_edge_filter #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_hit_edge_filter (
        .clk     (clk),
        .reset   (reset),
        .hit     (hit),
        .hit_rise(hit_rise)
    );

    always_comb begin
        state_n = state_q;
        reload  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                    reload  = 1'b1;
                end
            end
            ST_RUN: begin
                // The counter still shows the old value for a cycle after a
                // reload, so count_zero is ignored right after it.
                if (count_zero && !reload_d) begin
                    state_n = ST_OVER;
                end else if (pause) begin
                    state_n = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (!pause) begin
                    state_n = ST_RUN;
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_n = ST_RUN;
                    reload  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Time only advances and strobes only leave on cycles that stay in RUN;
    // a cycle that is about to pause or end the game is already frozen, which
    // is also what drops pending increments when the game ends.
    always_comb begin
        run_active = (state_q == ST_RUN) && (state_n == ST_RUN);
        tick       = run_active && (presc_q == PRE_LAST);
        issue_dec  = run_active && pend_dec_q;
        issue_inc  = run_active && !pend_dec_q && (pend_inc_q != '0);
        hit_count  = hit_rise && ((state_q == ST_RUN) || (state_q == ST_PAUSE));
        clear_all  = reload || (state_n == ST_IDLE) || (state_n == ST_OVER);
    end

    always_comb begin
        presc_n    = presc_q;
        pend_dec_n = pend_dec_q;
        pend_inc_n = pend_inc_q;
        if (clear_all) begin
            presc_n    = '0;
            pend_dec_n = 1'b0;
            pend_inc_n = '0;
        end else begin
            if (tick) begin
                presc_n = '0;
            end else if (run_active) begin
                presc_n = presc_q + 1'b1;
            end

            if (tick) begin
                pend_dec_n = 1'b1;
            end else if (issue_dec) begin
                pend_dec_n = 1'b0;
            end

            // A new hit and an issued increment in the same cycle cancel out.
            if (hit_count && !issue_inc) begin
                if (pend_inc_q != PEND_MAX) begin
                    pend_inc_n = pend_inc_q + 1'b1;
                end
            end else if (!hit_count && issue_inc) begin
                pend_inc_n = pend_inc_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            pend_inc_q <= '0;
            pend_dec_q <= 1'b0;
            reload_d   <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            presc_q    <= presc_n;
            pend_inc_q <= pend_inc_n;
            pend_dec_q <= pend_dec_n;
            reload_d   <= reload;
            inc_q      <= issue_inc;
            dec_q      <= issue_dec;
        end
    end

    assign timer_reload = reload && !reset;
    assign increment    = inc_q;
    assign decrement    = dec_q;
    assign state        = state_q;

endmodule

// File: tb/tb_timer_event_gen.sv
// tb/tb_timer_event_gen.sv - scoreboard bench for timer_event_gen (TICK_DIV=10, PEND_W=2)
module tb_timer_event_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       hit = 1'b0;
    logic       count_zero = 1'b0;
    logic       timer_reload;
    logic       increment;
    logic       decrement;
    logic [1:0] state;

    timer_event_gen #(
        .TICK_DIV    (10),
        .PEND_W      (2),
        .DEBOUNCE_CYC(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .hit         (hit),
        .count_zero  (count_zero),
        .timer_reload(timer_reload),
        .increment   (increment),
        .decrement   (decrement),
        .state       (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    function automatic string kn(input int k);
        case (k)
            0:       return "timer_reload";
            1:       return "increment";
            default: return "decrement";
        endcase
    endfunction

    task automatic expect_ev(input int k, input int at);
        ev_t e;
        e.kind = k;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event: got %s at cycle %0d, required no strobe", kn(k), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.at != cyc) begin
                fails++;
                $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                         kn(k), cyc, kn(e.kind), e.at);
            end
        end
    endtask

    // Monitor: every strobe the DUT presents is matched against the queue head.
    always @(negedge clk) begin
        if (increment && decrement) begin
            tests++;
            fails++;
            $display("FAIL exclusive: increment and decrement both 1 at cycle %0d, required at most one", cyc);
        end
        if (timer_reload) check_ev(0);
        if (decrement)    check_ev(2);
        if (increment)    check_ev(1);
    end

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d at cycle %0d, required %0d", name, act, cyc, req);
        end
    endtask

    // Inputs change 1 time unit after the rising edge that opens cycle n.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hit_pulse(input int at);
        goto(at);
        hit = 1'b1;
        goto(at + 1);
        hit = 1'b0;
    endtask

    initial begin
        goto(2);
        chk("reset_state", int'(state), 0);
        chk("reset_strobes", int'({timer_reload, increment, decrement}), 0);
        goto(3);
        reset = 1'b0;

`ifdef HIT_DEBOUNCE_EN
        goto(5);
        expect_ev(0, 5);
        start = 1'b1;
        goto(6);
        start = 1'b0;
        goto(7);
        pause = 1'b1;
        goto(10);
        hit = 1'b1;
        goto(15);
        hit = 1'b0;
        goto(20);
        hit = 1'b1;
        goto(40);
        hit = 1'b0;
        goto(60);
        chk("deb_pause_state", int'(state), 2);
        goto(80);
        expect_ev(1, 82);
        expect_ev(2, 91);
        pause = 1'b0;
        goto(100);
`else
        goto(5);
        expect_ev(0, 5);
        expect_ev(2, 17);
        start = 1'b1;
        goto(6);
        start = 1'b0;
        chk("run_after_start", int'(state), 1);

        expect_ev(1, 20);
        hit_pulse(18);
        expect_ev(1, 22);
        hit_pulse(20);
        expect_ev(1, 24);
        hit_pulse(22);

        // Hit edge on the prescaler wrap cycle: decrement wins, increment follows.
        expect_ev(2, 27);
        expect_ev(1, 28);
        hit_pulse(25);

        goto(30);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) hit_pulse(35 + 2 * i);
        goto(45);
        chk("pause_state", int'(state), 2);
        goto(55);
        expect_ev(1, 57);
        expect_ev(1, 58);
        expect_ev(1, 59);
        expect_ev(2, 63);
        pause = 1'b0;
        goto(57);
        chk("resume_state", int'(state), 1);

        expect_ev(1, 67);
        hit_pulse(65);
        hit_pulse(68);
        count_zero = 1'b1;
        goto(71);
        chk("over_state", int'(state), 3);
        hit_pulse(77);

        goto(80);
        expect_ev(0, 80);
        expect_ev(2, 92);
        start = 1'b1;
        goto(81);
        start = 1'b0;
        goto(82);
        count_zero = 1'b0;
        goto(83);
        chk("blank_after_reload", int'(state), 1);

        hit_pulse(93);
        reset = 1'b1;
        goto(96);
        chk("reset_mid_run", int'(state), 0);
        goto(97);
        reset = 1'b0;
        goto(98);
        chk("idle_after_reset", int'(state), 0);
        chk("strobes_after_reset", int'({timer_reload, increment, decrement}), 0);
        goto(110);
`endif

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_events: %0d expected strobes never seen, required 0 (next %s at cycle %0d)",
                     exp_q.size(), kn(exp_q[0].kind), exp_q[0].at);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
